onehot_state_monitor: RTL and testbench
=======================================

ONEHOT_STATE_MONITOR -- requirements
Module: onehot_state_monitor

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of saturating error counter.
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  onehot_in is sampled this cycle.
REQ-005 SHALL have port onehot_in  input  4  one-hot vending state code: IDLE=0001, COIN=0010, SELECT=0100, DISPENSE=1000.
REQ-006 SHALL have port clr_err  input  1  clears err_sticky and err_count.
REQ-007 SHALL have port state_binary  output  2  decoded state index, IDLE=0, COIN=1, SELECT=2, DISPENSE=3.
REQ-008 SHALL have port sync_ok  output  1  high while monitor is in TRACK.
REQ-009 SHALL have port code_err  output  1  one-cycle pulse on an illegal one-hot code.
REQ-010 SHALL have port trans_err  output  1  one-cycle pulse on an illegal state transition.
REQ-011 SHALL have port err_sticky  output  1  set by any error until clr_err.
REQ-012 SHALL have port err_count  output  ERR_CNT_W  saturating count of errors.

Function
REQ-013 All outputs SHALL be registered; response to a sample at edge N SHALL appear after edge N.
REQ-014 Monitor FSM SHALL have states SYNC, TRACK, FAULT.
REQ-015 in_valid=0 SHALL leave FSM, state_binary, and counters unchanged; code_err/trans_err = 0.
REQ-016 SYNC: valid sample equal to IDLE SHALL go to TRACK with state_binary=0; any other sample SHALL be ignored with no error.
REQ-017 TRACK: sample with zero or more than one bit set SHALL pulse code_err, go to FAULT, and hold state_binary.
REQ-018 TRACK: legal codes are same state (hold), state_binary+1 mod 4, or IDLE from any state (cancel); legal code SHALL update state_binary.
REQ-019 TRACK: any other valid one-hot code (skip or backward to non-IDLE) SHALL pulse trans_err, go to FAULT, hold state_binary.
REQ-020 FAULT: sync_ok=0; valid IDLE sample SHALL return to TRACK with state_binary=0 without error; all other samples ignored with no error.
REQ-021 Each code_err or trans_err pulse SHALL set err_sticky and increment err_count, saturating at 2^ERR_CNT_W-1.
REQ-022 clr_err SHALL zero err_sticky and err_count next edge; if an error occurs in the same cycle, result SHALL be err_sticky=1, err_count=1.
REQ-023 code_err and trans_err SHALL never assert in the same cycle; code check takes priority.

Reset
REQ-024 rst low SHALL immediately force FSM=SYNC, state_binary=0, sync_ok=0, code_err=0, trans_err=0, err_sticky=0, err_count=0.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight sample; after release the monitor SHALL require an IDLE sample to resync.

Structure
REQ-026 One-hot state codes, binary indices, and monitor FSM state encodings SHALL live in shared package vending_state_pkg.
REQ-027 Combinational one-hot legality check and index extraction SHALL be sub-module onehot_to_bin (inputs 4-bit code, outputs 2-bit index and valid flag).

Verification
REQ-028 Reset, then samples IDLE,COIN,SELECT,DISPENSE,IDLE -> state_binary 0,1,2,3,0; sync_ok=1 after first IDLE; no errors.
REQ-029 In TRACK at COIN, sample 0110 -> code_err pulse, err_count=1, sync_ok=0, state_binary stays 1; then IDLE -> sync_ok=1, state_binary=0.
REQ-030 In TRACK at IDLE, sample SELECT (0100) -> trans_err pulse, err_sticky=1, err_count=1; SELECT state from COIN then IDLE -> legal cancel, no error.
REQ-031 After reset, samples COIN, 0000 before any IDLE -> no errors, sync_ok=0; in_valid=0 with garbage onehot_in -> no change.
REQ-032 ERR_CNT_W=2: force 4 errors -> err_count saturates at 3; clr_err concurrent with 5th error -> err_count=1, err_sticky=1.
REQ-033 rst low mid-TRACK at DISPENSE -> all outputs zero immediately; after release DISPENSE sample ignored until IDLE seen.

Source files
------------

// File: rtl/vending_state_pkg.sv
// Shared vending state codes and monitor FSM encodings.
// One-hot codes, binary indices and a successor helper.
package vending_state_pkg;

  localparam logic [3:0] OH_IDLE     = 4'b0001;
  localparam logic [3:0] OH_COIN     = 4'b0010;
  localparam logic [3:0] OH_SELECT   = 4'b0100;
  localparam logic [3:0] OH_DISPENSE = 4'b1000;

  localparam logic [1:0] IDX_IDLE     = 2'd0;
  localparam logic [1:0] IDX_COIN     = 2'd1;
  localparam logic [1:0] IDX_SELECT   = 2'd2;
  localparam logic [1:0] IDX_DISPENSE = 2'd3;

  typedef enum logic [1:0] {
    MON_SYNC  = 2'd0,
    MON_TRACK = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_e;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/onehot_state_monitor_if.sv
// Sample/status bundle for the one-hot state monitor.
// master drives samples, slave reports status.
interface onehot_state_monitor_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic [3:0]           onehot_in;
  logic                 clr_err;
  logic [1:0]           state_binary;
  logic                 sync_ok;
  logic                 code_err;
  logic                 trans_err;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, onehot_in, clr_err,
    input  state_binary, sync_ok, code_err,
    input  trans_err, err_sticky, err_count
  );

  modport slave (
    input  in_valid, onehot_in, clr_err,
    output state_binary, sync_ok, code_err,
    output trans_err, err_sticky, err_count
  );
endinterface

// File: rtl/onehot_to_bin.sv
// One-hot legality check and index extraction.
// valid_o is high only when exactly one bit is set.
module onehot_to_bin
  import vending_state_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  // decode legal one-hot codes, flag everything else
  always_comb begin
    idx_o   = IDX_IDLE;
    valid_o = 1'b0;
    case (code_i)
      OH_IDLE: begin
        idx_o   = IDX_IDLE;
        valid_o = 1'b1;
      end
      OH_COIN: begin
        idx_o   = IDX_COIN;
        valid_o = 1'b1;
      end
      OH_SELECT: begin
        idx_o   = IDX_SELECT;
        valid_o = 1'b1;
      end
      OH_DISPENSE: begin
        idx_o   = IDX_DISPENSE;
        valid_o = 1'b1;
      end
      default: begin
        idx_o   = IDX_IDLE;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/onehot_state_monitor.sv
// Tracks a one-hot vending state stream and flags
// illegal codes and transitions; all outputs registered.
module onehot_state_monitor
  import vending_state_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           onehot_in,
  input  logic                 clr_err,
  output logic [1:0]           state_binary,
  output logic                 sync_ok,
  output logic                 code_err,
  output logic                 trans_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE =
    {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  mon_state_e           mon_q, mon_d;
  logic [1:0]           bin_q, bin_d;
  logic                 sync_q, sync_d;
  logic                 cerr_q, cerr_d;
  logic                 terr_q, terr_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] idx;
  logic       oh_ok;
  logic       is_idle;
  logic       legal_step;
  logic       err;

  onehot_to_bin u_dec (
    .code_i  (onehot_in),
    .idx_o   (idx),
    .valid_o (oh_ok)
  );

  assign is_idle = (onehot_in == OH_IDLE);

  assign legal_step = (idx == bin_q) ||
                      (idx == next_idx(bin_q)) ||
                      (idx == IDX_IDLE);

  // monitor FSM next state and error pulses
  always_comb begin
    mon_d  = mon_q;
    bin_d  = bin_q;
    cerr_d = 1'b0;
    terr_d = 1'b0;
    if (in_valid) begin
      unique case (mon_q)
        MON_SYNC, MON_FAULT: begin
          if (is_idle) begin
            mon_d = MON_TRACK;
            bin_d = IDX_IDLE;
          end
        end
        MON_TRACK: begin
          if (!oh_ok) begin
            cerr_d = 1'b1;
            mon_d  = MON_FAULT;
          end else if (legal_step) begin
            bin_d = idx;
          end else begin
            terr_d = 1'b1;
            mon_d  = MON_FAULT;
          end
        end
        default: begin
          mon_d = MON_SYNC;
          bin_d = IDX_IDLE;
        end
      endcase
    end
  end

  assign err    = cerr_d | terr_d;
  assign sync_d = (mon_d == MON_TRACK);

  // sticky flag and saturating counter; error beats clear
  always_comb begin
    sticky_d = sticky_q | err;
    cnt_d    = cnt_q;
    if (err && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
    if (clr_err) begin
      sticky_d = err;
      cnt_d    = err ? CNT_ONE : '0;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mon_q    <= MON_SYNC;
      bin_q    <= IDX_IDLE;
      sync_q   <= 1'b0;
      cerr_q   <= 1'b0;
      terr_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mon_q    <= mon_d;
      bin_q    <= bin_d;
      sync_q   <= sync_d;
      cerr_q   <= cerr_d;
      terr_q   <= terr_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state_binary = bin_q;
  assign sync_ok      = sync_q;
  assign code_err     = cerr_q;
  assign trans_err    = terr_q;
  assign err_sticky   = sticky_q;
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_onehot_state_monitor.sv
// Directed bench for onehot_state_monitor; a second
// instance with ERR_CNT_W=2 shares stimulus for saturation.
module tb_onehot_state_monitor;
  import vending_state_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  onehot_state_monitor_if #(.ERR_CNT_W(8)) bus ();
  onehot_state_monitor_if #(.ERR_CNT_W(2)) bus2 ();

  onehot_state_monitor #(.ERR_CNT_W(8)) u_dut (
    .clk          (clk),
    .rst          (rst_n),
    .in_valid     (bus.in_valid),
    .onehot_in    (bus.onehot_in),
    .clr_err      (bus.clr_err),
    .state_binary (bus.state_binary),
    .sync_ok      (bus.sync_ok),
    .code_err     (bus.code_err),
    .trans_err    (bus.trans_err),
    .err_sticky   (bus.err_sticky),
    .err_count    (bus.err_count)
  );

  onehot_state_monitor #(.ERR_CNT_W(2)) u_dut2 (
    .clk          (clk),
    .rst          (rst_n),
    .in_valid     (bus2.in_valid),
    .onehot_in    (bus2.onehot_in),
    .clr_err      (bus2.clr_err),
    .state_binary (bus2.state_binary),
    .sync_ok      (bus2.sync_ok),
    .code_err     (bus2.code_err),
    .trans_err    (bus2.trans_err),
    .err_sticky   (bus2.err_sticky),
    .err_count    (bus2.err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic clr);
    bus.in_valid   = v;
    bus.onehot_in  = c;
    bus.clr_err    = clr;
    bus2.in_valid  = v;
    bus2.onehot_in = c;
    bus2.clr_err   = clr;
  endtask

  task automatic step(input logic v, input logic [3:0] c,
                      input logic clr);
    @(negedge clk);
    drive(v, c, clr);
    @(posedge clk);
    #1;
    drive(1'b0, 4'b0000, 1'b0);
  endtask

  // status snapshot: {bin, sync, cerr, terr, sticky}
  function automatic logic [5:0] st1();
    return {bus.state_binary, bus.sync_ok, bus.code_err,
            bus.trans_err, bus.err_sticky};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (st1() !== 6'b000000 || bus.err_count !== 8'd0) begin
      $display("FAIL reset: got st=%b cnt=%0d want 000000/0",
               st1(), bus.err_count);
    end else passed++;
    total++;
    if (bus2.err_count !== 2'd0 || bus2.sync_ok !== 1'b0)
      $display("FAIL reset2: got cnt=%0d sync=%b want 0/0",
               bus2.err_count, bus2.sync_ok);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [3:0] codes [5];
    logic [1:0] exp   [5];
    codes = '{OH_IDLE, OH_COIN, OH_SELECT, OH_DISPENSE, OH_IDLE};
    exp   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, codes[i], 1'b0);
      total++;
      if (st1() !== {exp[i], 4'b1000} || bus.err_count !== 8'd0)
        $display("FAIL seq[%0d]: got st=%b cnt=%0d want %b/0",
                 i, st1(), bus.err_count, {exp[i], 4'b1000});
      else passed++;
    end
  endtask

  task automatic test_code_err();
    step(1'b1, OH_COIN, 1'b0);
    step(1'b1, 4'b0110, 1'b0);
    total++;
    if (st1() !== 6'b010101 || bus.err_count !== 8'd1)
      $display("FAIL code_err: got st=%b cnt=%0d want 010101/1",
               st1(), bus.err_count);
    else passed++;
    step(1'b0, 4'b1111, 1'b0);
    total++;
    if (st1() !== 6'b010001 || bus.err_count !== 8'd1)
      $display("FAIL code_pulse: got st=%b cnt=%0d want 010001/1",
               st1(), bus.err_count);
    else passed++;
    step(1'b1, OH_IDLE, 1'b0);
    total++;
    if (st1() !== 6'b001001)
      $display("FAIL code_resync: got st=%b want 001001", st1());
    else passed++;
  endtask

  task automatic test_trans_err();
    step(1'b0, 4'b0000, 1'b1);
    total++;
    if (bus.err_sticky !== 1'b0 || bus.err_count !== 8'd0)
      $display("FAIL clr: got sticky=%b cnt=%0d want 0/0",
               bus.err_sticky, bus.err_count);
    else passed++;
    step(1'b1, OH_SELECT, 1'b0);
    total++;
    if (st1() !== 6'b000011 || bus.err_count !== 8'd1)
      $display("FAIL trans_err: got st=%b cnt=%0d want 000011/1",
               st1(), bus.err_count);
    else passed++;
    step(1'b1, OH_IDLE, 1'b0);
    step(1'b1, OH_COIN, 1'b0);
    step(1'b1, OH_SELECT, 1'b0);
    total++;
    if (st1() !== 6'b101001)
      $display("FAIL sel: got st=%b want 101001", st1());
    else passed++;
    step(1'b1, OH_IDLE, 1'b0);
    total++;
    if (st1() !== 6'b001001 || bus.err_count !== 8'd1)
      $display("FAIL cancel: got st=%b cnt=%0d want 001001/1",
               st1(), bus.err_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    step(1'b1, OH_COIN, 1'b0);
    step(1'b1, OH_COIN, 1'b0);
    total++;
    if (st1() !== 6'b011001)
      $display("FAIL hold: got st=%b want 011001", st1());
    else passed++;
    step(1'b1, OH_SELECT, 1'b0);
    step(1'b1, OH_DISPENSE, 1'b0);
    step(1'b1, OH_COIN, 1'b0);
    total++;
    if (st1() !== 6'b110011 || bus.err_count !== 8'd2)
      $display("FAIL back: got st=%b cnt=%0d want 110011/2",
               st1(), bus.err_count);
    else passed++;
    step(1'b1, OH_DISPENSE, 1'b0);
    total++;
    if (st1() !== 6'b110001 || bus.err_count !== 8'd2)
      $display("FAIL fault_ign: got st=%b cnt=%0d want 110001/2",
               st1(), bus.err_count);
    else passed++;
  endtask

  task automatic test_sync_ignore();
    do_reset();
    step(1'b1, OH_COIN, 1'b0);
    total++;
    if (st1() !== 6'b000000 || bus.err_count !== 8'd0)
      $display("FAIL sync_coin: got st=%b cnt=%0d want 000000/0",
               st1(), bus.err_count);
    else passed++;
    step(1'b1, 4'b0000, 1'b0);
    total++;
    if (st1() !== 6'b000000 || bus.err_count !== 8'd0)
      $display("FAIL sync_zero: got st=%b cnt=%0d want 000000/0",
               st1(), bus.err_count);
    else passed++;
    step(1'b1, OH_IDLE, 1'b0);
    step(1'b1, OH_COIN, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    total++;
    if (st1() !== 6'b011000 || bus.err_count !== 8'd0)
      $display("FAIL noval: got st=%b cnt=%0d want 011000/0",
               st1(), bus.err_count);
    else passed++;
  endtask

  task automatic test_saturate();
    logic [3:0] bad [4];
    bad = '{4'b0011, 4'b0000, 4'b1100, 4'b0101};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, OH_IDLE, 1'b0);
      step(1'b1, bad[i], 1'b0);
    end
    total++;
    if (bus2.err_count !== 2'd3 || bus2.err_sticky !== 1'b1)
      $display("FAIL sat2: got cnt=%0d sticky=%b want 3/1",
               bus2.err_count, bus2.err_sticky);
    else passed++;
    total++;
    if (bus.err_count !== 8'd4)
      $display("FAIL cnt8: got cnt=%0d want 4", bus.err_count);
    else passed++;
    step(1'b1, OH_IDLE, 1'b0);
    step(1'b1, 4'b1111, 1'b1);
    total++;
    if (bus2.err_count !== 2'd1 || bus2.err_sticky !== 1'b1 ||
        bus2.code_err !== 1'b1)
      $display("FAIL clr_err2: got cnt=%0d sticky=%b want 1/1",
               bus2.err_count, bus2.err_sticky);
    else passed++;
    total++;
    if (bus.err_count !== 8'd1 || bus.err_sticky !== 1'b1)
      $display("FAIL clr_err8: got cnt=%0d sticky=%b want 1/1",
               bus.err_count, bus.err_sticky);
    else passed++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, OH_IDLE, 1'b0);
    step(1'b1, OH_COIN, 1'b0);
    step(1'b1, OH_SELECT, 1'b0);
    step(1'b1, OH_DISPENSE, 1'b0);
    total++;
    if (st1() !== 6'b111001)
      $display("FAIL pre_rst: got st=%b want 111001", st1());
    else passed++;
    @(negedge clk);
    drive(1'b1, OH_IDLE, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (st1() !== 6'b000000 || bus.err_count !== 8'd0)
      $display("FAIL rst_mid: got st=%b cnt=%0d want 000000/0",
               st1(), bus.err_count);
    else passed++;
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    step(1'b1, OH_DISPENSE, 1'b0);
    total++;
    if (st1() !== 6'b000000 || bus.err_count !== 8'd0)
      $display("FAIL post_rst: got st=%b cnt=%0d want 000000/0",
               st1(), bus.err_count);
    else passed++;
    step(1'b1, OH_IDLE, 1'b0);
    total++;
    if (st1() !== 6'b001000)
      $display("FAIL resync: got st=%b want 001000", st1());
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_sequence();
    test_code_err();
    test_trans_err();
    test_back_to_back();
    test_sync_ignore();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
